// File: rtl/tmul_tile_loader.sv
// tmul_tile_loader: packs a word stream into one a-vector plus b-matrix tile
// and holds it for the 8x8 tile multiplier until the tile is consumed.
module tmul_tile_loader #(
  parameter int DW = 32,
  parameter int N  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [DW-1:0]     a_out [N-1:0],
  output logic [N*DW-1:0]   b_out [N-1:0],
  output logic              tile_valid,
  input  logic              tile_ready,
  output logic              err,
  output logic [15:0]       tile_count
);

  localparam int FRAME = N + N * N;
  localparam int IDX_W = $clog2(FRAME);
  localparam int AW    = $clog2(N);
  localparam int LAST  = FRAME - 1;

  typedef enum logic {LOAD, HOLD} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]     a_q [N-1:0];
  logic [DW-1:0]     a_d [N-1:0];
  logic [N*DW-1:0]   b_q [N-1:0];
  logic [N*DW-1:0]   b_d [N-1:0];
  logic              err_q, err_d;
  logic [15:0]       tile_count_q, tile_count_d;

  logic              accept;
  logic              is_a;
  logic              at_last;
  logic [IDX_W-1:0]  m;
  logic [AW-1:0]     row;
  logic [AW-1:0]     col;

  assign accept  = in_valid && in_ready;
  assign is_a    = idx_q < IDX_W'(N);
  assign at_last = idx_q == IDX_W'(LAST);
  assign m       = idx_q - IDX_W'(N);
  assign row     = AW'(m / IDX_W'(N));
  assign col     = AW'(m % IDX_W'(N));

  // Register stage: every flop returns to its reset value on a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      a_q          <= '{default: '0};
      b_q          <= '{default: '0};
      err_q        <= 1'b0;
      tile_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      err_q        <= err_d;
      tile_count_q <= tile_count_d;
    end
  end

  // Next state: frame boundary checks on each accepted word, tile release in HOLD.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_d        = 1'b0;
    tile_count_d = tile_count_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (at_last && in_last) begin
            state_d = HOLD;
            idx_d   = '0;
          end else if (at_last || in_last) begin
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (tile_ready) begin
          state_d      = LOAD;
          tile_count_d = tile_count_q + 16'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Datapath: drop each accepted word into its a element or b row slot in place.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (accept) begin
      if (is_a) begin
        a_d[idx_q[AW-1:0]] = in_data;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (col == AW'(k)) begin
            b_d[row][DW*k +: DW] = in_data;
          end
        end
      end
    end
  end

  // Outputs: everything comes from registered state; in_ready is also gated by rst.
  always_comb begin
    in_ready   = (state_q == LOAD) && !rst;
    tile_valid = (state_q == HOLD);
    err        = err_q;
    tile_count = tile_count_q;
    a_out      = a_q;
    b_out      = b_q;
  end

endmodule

// File: doc/tmul_tile_loader.md
# tmul_tile_loader

Stream-to-tile packer that feeds the 8x8 tile multiplier (`TMUL_32_8mul8`). It accepts a stream of 32-bit words over a valid/ready handshake and assembles one tile. A tile is the operand vector `a[0..7]` plus the matrix `b`, packed as eight 256-bit rows. When the tile is complete, the block presents it to the multiplier under a tile_valid/tile_ready handshake. It sits between the operand DMA/stream source and the multiplier's `a` / `b` inputs.

## Interface
- DW, 32, element width in bits
- N, 8, vector length and matrix dimension; a frame is N + N*N words (72 at defaults)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  DW  stream word
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a word this cycle
- in_last  in  1  marks the final word of a frame
- a_out  out  N x DW (unpacked [N-1:0])  operand vector, element j
- b_out  out  N x N*DW (unpacked [N-1:0])  matrix rows; row r element k at bits [DW*k+DW-1 : DW*k]
- tile_valid  out  1  a_out/b_out hold a complete tile
- tile_ready  in  1  multiplier consumes the tile
- err  out  1  one-cycle pulse on a framing error
- tile_count  out  16  tiles delivered since reset, wraps at 0xFFFF -> 0

## Operation
- States: LOAD, HOLD.
- Word index idx counts 0..N+N*N-1.
- A word is accepted when in_valid && in_ready at a rising edge.
- in_ready = (state == LOAD) && !rst. It is combinational from registered state.
- Accepted word placement:
  - idx < N: word goes to a_out[idx].
  - Otherwise, with m = idx - N: word goes to b_out[m / N][DW*(m % N) +: DW].
- Frame order is therefore a[0..7], then b row 0 elements 0..7, then row 1, and so on through row 7.
- a_out/b_out are written in place during LOAD. Their contents are defined only while tile_valid = 1.
- Accepted word with idx = last (71):
  - With in_last = 1: go to HOLD, reset idx to 0.
  - With in_last = 0: framing error. Pulse err, reset idx to 0, stay in LOAD, deliver no tile.
- Accepted word with idx < last and in_last = 1: framing error. Pulse err, reset idx to 0, stay in LOAD, discard the partial frame.
- In HOLD: tile_valid = 1, in_ready = 0, a_out/b_out stable. in_data/in_valid are ignored.
- In HOLD with tile_ready = 1 at an edge: go to LOAD and increment tile_count.
- in_valid gaps during LOAD are legal; idx advances only on an accepted word.
- All arithmetic on idx and tile_count is unsigned. tile_count wraps modulo 2^16.

## Timing
- Reset values:
  - state = LOAD, idx = 0
  - all a_out / b_out = 0
  - tile_valid = 0, err = 0, tile_count = 0
  - in_ready = 0 while rst = 1; it is 1 in the first cycle after rst deasserts.
- Last word accepted at edge E: tile_valid = 1 from the cycle after E.
- Handshake (tile_valid && tile_ready) at edge F:
  - tile_valid = 0 and in_ready = 1 from the cycle after F.
  - tile_count updates at F.
- Minimum period per tile is 73 cycles (72 words + 1 HOLD cycle when tile_ready is held high).
- err is asserted for exactly the cycle after the offending acceptance edge. It is never asserted two cycles in a row for one event.
- rst mid-frame or in HOLD: everything returns to reset values on that edge. The partial or held tile is lost, and err is not pulsed.
- No combinational path from in_* or tile_ready to any output except through state.

## Test plan
- Reset: hold rst for 2 cycles, with in_valid = 1 throughout.
  - During rst: in_ready = 0, all outputs 0, no word accepted.
  - First cycle after release: in_ready = 1.
- Nominal frame: words = idx+1, in_last on word 72, tile_ready = 1.
  - a_out[j] = j+1.
  - b_out[r][32k+:32] = 9+8r+k (e.g. b_out[7][255:224] = 72).
  - tile_valid high for exactly 1 cycle; tile_count = 1; in_ready returns the next cycle.
- Backpressure: same frame, tile_ready = 0 for 5 cycles, in_valid held 1 with data 0xDEADBEEF.
  - tile_valid stays 1 and in_ready stays 0.
  - a_out/b_out are unchanged; the next frame's first word is accepted only after the handshake.
- Early in_last: assert in_last on word 10.
  - err pulses 1 cycle and tile_valid stays 0.
  - A following correct 72-word frame (values 100+idx) delivers with a_out[0] = 100.
- Missing in_last: 72 words with in_last = 0.
  - err pulses after word 72; no tile is delivered; tile_count unchanged.
- Mid-frame reset: assert rst after word 40, then send a nominal frame with random in_valid gaps.
  - Exactly one tile is delivered, with correct contents; tile_count = 1; err never asserted.
